// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave controller: FSM state encoding,
// command codes and the default command frame width.
package spi_pkg;

    localparam int FRAME_WIDTH_DEF = 10;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4,
        ST_LOAD      = 3'd5,
        ST_SHIFT     = 3'd6
    } state_e;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser for the MISO readback path.
// serial_out is registered and reads 0 whenever no bit is being shifted.
module spi_tx_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] data,
    output logic             serial_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sreg_r;
    logic [CW-1:0]    cnt_r;
    logic             out_r;

    // Load, shift and abort sequencing; out_r carries the bit currently on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_r <= '0;
            cnt_r  <= '0;
            out_r  <= 1'b0;
        end else if (abort) begin
            cnt_r  <= '0;
            out_r  <= 1'b0;
        end else if (load) begin
            out_r  <= data[WIDTH-1];
            sreg_r <= {data[WIDTH-2:0], 1'b0};
            cnt_r  <= CW'(WIDTH);
        end else if (cnt_r != CW'(0)) begin
            out_r  <= (cnt_r == CW'(1)) ? 1'b0 : sreg_r[WIDTH-1];
            sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
            cnt_r  <= cnt_r - CW'(1);
        end
    end

    assign serial_out = out_r;
    assign busy       = (cnt_r != CW'(0));

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: deserialises MOSI into command frames for the command
// RAM and serialises the RAM readback onto MISO.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_WIDTH = FRAME_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ss_n,
    input  logic                    mosi,
    input  logic                    tx_valid,
    input  logic [FRAME_WIDTH-3:0]  tx_data,
    output logic                    miso,
    output logic                    rx_valid,
    output logic [FRAME_WIDTH-1:0]  rx_data
);

    localparam int RD_WIDTH = FRAME_WIDTH - 2;
    localparam int CNT_W    = $clog2(FRAME_WIDTH + 1);

    state_e                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [FRAME_WIDTH-2:0] shift_r;
    logic                   rd_addr_seen_r;
    logic                   rx_valid_r;
    logic [FRAME_WIDTH-1:0] rx_data_r;

    logic [FRAME_WIDTH-1:0] frame_s;
    logic                   in_frame_s;
    logic                   frame_done_s;
    logic                   load_s;
    logic                   busy_s;
    logic                   miso_s;

    // Frame assembly and completion/load strobes derived from the current state.
    always_comb begin
        frame_s      = {shift_r, mosi};
        in_frame_s   = (state_r == ST_WRITE) || (state_r == ST_READ_ADD) ||
                       (state_r == ST_READ_DATA);
        frame_done_s = in_frame_s && !ss_n && (cnt_r == CNT_W'(FRAME_WIDTH - 1));
        load_s       = (state_r == ST_LOAD) && !ss_n;
    end

    // Main FSM: command decode, frame capture and readback sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            shift_r        <= '0;
            rd_addr_seen_r <= 1'b0;
            rx_valid_r     <= 1'b0;
            rx_data_r      <= '0;
        end else begin
            rx_valid_r <= 1'b0;
            if (ss_n && (state_r != ST_IDLE)) begin
                state_r <= ST_IDLE;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!ss_n) begin
                            state_r <= ST_CHK_CMD;
                            cnt_r   <= '0;
                        end
                    end
                    ST_CHK_CMD: begin
                        shift_r <= frame_s[FRAME_WIDTH-2:0];
                        cnt_r   <= CNT_W'(1);
                        if (!mosi)
                            state_r <= ST_WRITE;
                        else if (rd_addr_seen_r)
                            state_r <= ST_READ_DATA;
                        else
                            state_r <= ST_READ_ADD;
                    end
                    ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                        // Once the counter saturates, extra MOSI bits are ignored.
                        if (cnt_r != CNT_W'(FRAME_WIDTH)) begin
                            shift_r <= frame_s[FRAME_WIDTH-2:0];
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                        if (frame_done_s) begin
                            rx_data_r  <= frame_s;
                            rx_valid_r <= 1'b1;
                            if ((state_r == ST_READ_ADD) &&
                                (frame_s[FRAME_WIDTH-1 -: 2] == CMD_RD_ADDR))
                                rd_addr_seen_r <= 1'b1;
                        end
                        if ((state_r == ST_READ_DATA) && (cnt_r == CNT_W'(FRAME_WIDTH)) &&
                            (rx_data_r[FRAME_WIDTH-1 -: 2] == CMD_RD_DATA) && tx_valid)
                            state_r <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        state_r <= ST_SHIFT;
                        cnt_r   <= '0;
                    end
                    ST_SHIFT: begin
                        if (busy_s)
                            cnt_r <= cnt_r + CNT_W'(1);
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
            // The last readback bit completes the read even if ss_n rises in that cycle.
            if ((state_r == ST_SHIFT) && busy_s && (cnt_r == CNT_W'(RD_WIDTH - 1)))
                rd_addr_seen_r <= 1'b0;
        end
    end

    spi_tx_shifter #(
        .WIDTH (RD_WIDTH)
    ) u_tx_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .abort      (ss_n),
        .data       (tx_data),
        .serial_out (miso_s),
        .busy       (busy_s)
    );

    assign miso     = miso_s;
    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave controller that sequences the single-port command RAM. Deserialises MOSI into 10-bit command frames, presents each completed frame to the RAM with a one-cycle `rx_valid` strobe, and serialises the RAM's 8-bit read data back on MISO. Sits between the SPI pins and the RAM; the wrapper connects `rx_data`/`rx_valid` to the RAM's `din`/`rx_valid` and the RAM's `dout`/`tx_valid` to `tx_data`/`tx_valid`.

## Interface
- `FRAME_WIDTH`, 10, command frame width; bits [FRAME_WIDTH-1:FRAME_WIDTH-2] are the command, the rest are payload.
- `RD_WIDTH`, FRAME_WIDTH-2, readback width (local, not overridable).

- `clk`  in  1  system clock; MOSI and SS_n are sampled on its rising edge (one SPI bit per clk).
- `rst`  in  1  synchronous, active-high reset.
- `ss_n`  in  1  slave select, active low.
- `mosi`  in  1  serial data in, MSB first.
- `tx_valid`  in  1  RAM readback ready (combinational from RAM).
- `tx_data`  in  RD_WIDTH  RAM read data (registered in RAM).
- `miso`  out  1  serial data out, MSB first; 0 when not shifting.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` holds a complete frame.
- `rx_data`  out  FRAME_WIDTH  last complete frame; held until next completion.

## Operation
- Reset: state IDLE, `miso`=0, `rx_valid`=0, `rx_data`=0, bit counter 0, `rd_addr_seen`=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, and LOAD and SHIFT (readback sub-phases of READ_DATA).
- IDLE: `ss_n`=0 -> CHK_CMD.
- CHK_CMD: samples frame bit 9 into the shift register.
  - `mosi`=0 -> WRITE (covers commands 00 write-address and 01 write-data).
  - `mosi`=1 with `rd_addr_seen`=0 -> READ_ADD.
  - `mosi`=1 with `rd_addr_seen`=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift in the remaining 9 bits.
  - After the 10th bit: `rx_data` <= frame and `rx_valid` pulses for one cycle.
  - Further MOSI bits are ignored until `ss_n` rises.
- READ_ADD: on completion, `rd_addr_seen` <= 1 only if the frame command is 10.
- READ_DATA: on completion, if the frame command is 11, wait for `tx_valid`=1.
  - The cycle after `tx_valid` is first seen, latch `tx_data` (LOAD). This covers the RAM's registered read.
  - SHIFT drives 8 bits on `miso`, MSB first, one per clk.
  - After bit 0, `rd_addr_seen` <= 0 and `miso` returns to 0.
  - If the command is not 11, no readback occurs and `rd_addr_seen` is unchanged.
- `ss_n`=1 in any non-IDLE state -> IDLE next cycle.
  - Mid-frame: no `rx_valid`, counter cleared, `rx_data` and `rd_addr_seen` unchanged.
  - Mid-readback: shifting aborts, `miso`=0, `rd_addr_seen` unchanged.
- `rst` has priority over all other events and takes effect on the next clock edge mid-operation.

## Timing
- Entry to CHK_CMD is one cycle after `ss_n` is first sampled low in IDLE. Call that cycle c.
- Frame bits 9..0 are sampled in cycles c..c+9.
- `rx_valid`=1 and the new `rx_data` appear in cycle c+10 only.
- Readback with `tx_valid` high at c+10: `tx_data` is latched at the end of c+11, and `miso` carries bit 7 in c+12 through bit 0 in c+19.
- `rd_addr_seen` clears at the end of c+19.
- Minimum `ss_n` low time: 11 cycles for a write or read-address frame, 20 cycles for a read-data frame.
- Back-to-back frames require `ss_n` to be high for at least one sampled cycle between them.

## Structure
- Shared package `spi_pkg`: state enum encoding, command localparams (`CMD_WR_ADDR`=00, `CMD_WR_DATA`=01, `CMD_RD_ADDR`=10, `CMD_RD_DATA`=11), and the default FRAME_WIDTH.
- One sub-module, `spi_tx_shifter`: a parallel-load, MSB-first, RD_WIDTH shifter with a `load`/`busy` interface, used for the MISO path.
- The FSM, the receive shift register and the counter live in the top module.

## Test plan
- Reset: assert `rst` mid-frame -> all outputs 0 on the next cycle, state IDLE, and the next frame is decoded as a fresh CHK_CMD.
- Write: send 00_0000_0101 then 01_1010_1010 in two `ss_n` windows -> `rx_valid` pulses at c+10 of each window, with `rx_data`=0x005 then 0x1AA; `miso` stays 0.
- Read: send 10_0000_0101, then 11_xxxx_xxxx with the RAM model returning 0xAA -> `miso` sequence 1,0,1,0,1,0,1,0 in c+12..c+19, and `rd_addr_seen` returns to 0.
- Abort: raise `ss_n` after 6 bits -> no `rx_valid`, `rx_data` unchanged, and the next full frame is captured correctly.
- Read-data without prior read-address: the first-bit=1 frame goes to READ_ADD; sending 11_... there sets no flag and produces no MISO activity.
- Abort mid-readback at c+15 -> `miso`=0 from c+16, and `rd_addr_seen` stays 1 so the next first-bit-1 frame enters READ_DATA.
